// File: rtl/pc_select_controller.sv
// Next-PC sequencer: owns the PC, drives the fetch mux inputs/select and buffers one redirect.
// Optional macro PC_SELECT_BYPASS_EN forwards an unbuffered redirect to the mux in its accept cycle.
module pc_select_controller #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int               INC      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch_valid,
   input  logic [WIDTH-1:0] branch_target,
   output logic             branch_ready,
   output logic [WIDTH-1:0] seq_pc,
   output logic [WIDTH-1:0] tgt_pc,
   output logic             mux_select,
   input  logic [WIDTH-1:0] mux_out,
   output logic [WIDTH-1:0] pc,
   output logic             pc_valid,
   output logic             flush
);

   localparam logic [0:0] ST_BOOT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic             pending_q, pending_d;
   logic             flush_q, flush_d;
   logic             accept;
   logic             bypass;

   assign accept = branch_valid && !pending_q;

`ifdef PC_SELECT_BYPASS_EN
   // A fresh redirect with nothing buffered and no stall goes straight to the mux.
   assign bypass = (state_q == ST_RUN) && !stall && accept;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
      state_d   = ST_RUN;
      pc_d      = pc_q;
      tgt_d     = tgt_q;
      pending_d = pending_q;
      flush_d   = 1'b0;

      if (accept) begin
         tgt_d     = branch_target;
         pending_d = 1'b1;
      end

      // The PC only ever loads from the external mux, even when redirecting.
      if (state_q == ST_RUN && !stall) begin
         pc_d = mux_out;
         if (pending_q || bypass) begin
            pending_d = 1'b0;
            flush_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q   <= ST_BOOT;
         pc_q      <= RESET_PC;
         tgt_q     <= '0;
         pending_q <= 1'b0;
         flush_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         tgt_q     <= tgt_d;
         pending_q <= pending_d;
         flush_q   <= flush_d;
      end
   end

   assign branch_ready = !pending_q;
   assign seq_pc       = pc_q + WIDTH'(INC);
   assign tgt_pc       = bypass ? branch_target : tgt_q;
   assign mux_select   = pending_q | bypass;
   assign pc           = pc_q;
   assign pc_valid     = (state_q == ST_RUN);
   assign flush        = flush_q;

endmodule

// File: doc/pc_select_controller.md
# pc_select_controller

Sequencer for the instruction-fetch next-PC multiplexer. Owns the program-counter register, drives the multiplexer's two inputs and its select, and loads the multiplexer output back into the PC each unstalled cycle. Accepts branch redirects through a valid/ready handshake, buffers one pending redirect across stalls, and flags the cycle the PC jumps so downstream fetch can squash the wrong-path instruction.

## Interface
Parameters:
- WIDTH, 32, PC and address width
- RESET_PC, 0, PC value loaded on reset
- INC, 4, sequential PC increment

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  fetch stall; PC and pending redirect held while high
- branch_valid  in  1  redirect request
- branch_target  in  WIDTH  redirect address, sampled on handshake
- branch_ready  out  1  controller can accept a redirect
- seq_pc  out  WIDTH  pc + INC, drives multiplexer input a
- tgt_pc  out  WIDTH  buffered target, drives multiplexer input b
- mux_select  out  1  multiplexer select; 0 = a (sequential), 1 = b (target)
- mux_out  in  WIDTH  multiplexer output, next-PC source
- pc  out  WIDTH  current fetch address
- pc_valid  out  1  pc is a real fetch address
- flush  out  1  one-cycle pulse: pc took a redirect this cycle

## Operation
- States: BOOT, RUN. Separate flag `pending` marks a buffered redirect.
- Reset (rst high at an edge): pc=RESET_PC, tgt_pc=0, pending=0, state=BOOT. Outputs: pc_valid=0, mux_select=0, branch_ready=1, flush=0. rst overrides every other input, and any pending redirect is dropped.
- BOOT: lasts exactly one cycle after rst deasserts. pc is held and pc_valid=0. Goes to RUN unconditionally, stall ignored. A handshake in BOOT is still accepted.
- RUN: pc_valid=1.
  - !stall, !pending: pc <= mux_out (mux_select=0, so pc+INC).
  - !stall, pending: pc <= mux_out (mux_select=1, so tgt_pc); pending <= 0; flush=1 in the following cycle.
  - stall: pc, pending and tgt_pc held; flush=0.
- Handshake:
  - branch_ready = !pending.
  - Accept when branch_valid && branch_ready. tgt_pc <= branch_target, pending <= 1.
  - branch_valid while branch_ready=0 is not accepted. The requester must hold the request, and it is accepted once pending clears.
- mux_select is `pending`, a registered value.
- seq_pc = pc + INC modulo 2^WIDTH. Wrap from 2^WIDTH−INC to 0 is legal and silent.
- pc loads only from mux_out, never from internal shortcuts. A wrong mux_out propagates to pc.

## Timing
- Sequential step: pc advances by INC once per unstalled RUN cycle, visible the cycle after the edge.
- Redirect latency without bypass:
  - Handshake in cycle N.
  - mux_select=1 and tgt_pc=target in cycle N+1.
  - pc=target and flush=1 in cycle N+2, provided stall is low in N+1.
  - Each stalled cycle in N+1 adds one cycle.
- Back-to-back redirects: branch_ready is low from N+1 until the redirect is consumed. The earliest next accept is the cycle in which pc=target.
- stall and branch accept in the same cycle: the accept still occurs and pc is held.
- Reset mid-redirect: the pending redirect is discarded, and pc returns to RESET_PC the cycle after the reset edge.

## Configuration
- Macro `PC_SELECT_BYPASS_EN`.
- Defined:
  - In a RUN cycle with no pending redirect and stall low, an accepted redirect drives mux_select=1 and tgt_pc=branch_target combinationally in that same cycle.
  - pc=target and flush=1 in cycle N+1, for a latency of 1.
  - If stall is high in the accept cycle, the redirect is buffered and follows the normal path.
- Undefined: mux_select and tgt_pc are purely registered, with the 2-cycle latency described above.

## Test plan
- Reset release, no stall, RESET_PC=0 -> pc_valid 0 for one cycle, then pc sequence 0, 4, 8, 12.
- Branch to 0x100 accepted at pc=8, no stall -> next pc 0x100 two cycles later (one with `PC_SELECT_BYPASS_EN`), flush pulse exactly one cycle, then 0x104.
- Branch to 0x200 accepted, stall held 3 cycles in N+1 -> pc frozen, branch_ready 0 throughout; pc=0x200 the cycle after stall drops.
- Second branch_valid (0x300) held while first pending -> not accepted until pending clears; both targets reached in order with no third flush.
- RESET_PC=0xFFFFFFF8, no stall -> pc 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- rst asserted the cycle after a branch handshake -> pc=RESET_PC, pending cleared, branch_ready 1, no flush, target never reached.
